// File: rtl/pomodoro_sequencer.sv
`default_nettype none
//==============================================================================
// Module   : pomodoro_sequencer
// Brief    : Work / short-break / long-break countdown sequencer driven by a
//            one-second prescaler. Define POMO_AUTO_ADVANCE_EN to keep the
//            countdown running across WORK<->break transitions.
// Revision : 1.0 - initial release
//==============================================================================
module pomodoro_sequencer #(
    parameter int CLK_HZ            = 100000000,
    parameter int MIN_W             = 7,
    parameter int SESSIONS_PER_LONG = 4,
    parameter int SHORT_BREAK_MIN   = 5,
    parameter int LONG_BREAK_MIN    = 15
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start_pause,
    input  logic             skip,
    input  logic [1:0]       work_sel,
    output logic [MIN_W-1:0] minutes,
    output logic [5:0]       seconds,
    output logic [1:0]       phase,
    output logic             running,
    output logic [3:0]       session_cnt,
    output logic             phase_done
);

    localparam int                   c_PRESC_W   = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [c_PRESC_W-1:0] c_PRESC_MAX = c_PRESC_W'(CLK_HZ - 1);
    localparam logic [3:0]           c_SPL       = 4'(SESSIONS_PER_LONG);
    localparam logic [MIN_W-1:0]     c_SHORT_MIN = MIN_W'(SHORT_BREAK_MIN);
    localparam logic [MIN_W-1:0]     c_LONG_MIN  = MIN_W'(LONG_BREAK_MIN);

`ifdef POMO_AUTO_ADVANCE_EN
    localparam logic c_AUTO_ADVANCE = 1'b1;
`else
    localparam logic c_AUTO_ADVANCE = 1'b0;
`endif

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_WORK  = 2'b01,
        ST_SHORT = 2'b10,
        ST_LONG  = 2'b11
    } state_t;

    state_t               r_state,    w_state_nxt;
    logic                 r_running,  w_running_nxt;
    logic [MIN_W-1:0]     r_min,      w_min_nxt;
    logic [5:0]           r_sec,      w_sec_nxt;
    logic [3:0]           r_cnt,      w_cnt_nxt;
    logic [c_PRESC_W-1:0] r_presc,    w_presc_nxt;
    logic                 r_done,     w_done_nxt;
    logic [1:0]           r_work_sel, w_sel_nxt;
    logic                 r_sp_prev;
    logic                 r_skip_prev;

    logic                 w_sp_edge;
    logic                 w_skip_edge;
    logic                 w_tick;
    logic                 w_phase_end;
    logic [3:0]           w_cnt_inc;

    // {minutes, seconds} for each work preset
    function automatic logic [MIN_W+5:0] f_work_time(input logic [1:0] sel);
        logic [MIN_W+5:0] v;
        v = '0;
        case (sel)
            2'b00: v = {MIN_W'(0),  6'd10};
            2'b01: v = {MIN_W'(20), 6'd0};
            2'b10: v = {MIN_W'(25), 6'd0};
            2'b11: v = {MIN_W'(30), 6'd0};
        endcase
        return v;
    endfunction

    assign w_sp_edge   = start_pause & ~r_sp_prev;
    assign w_skip_edge = skip & ~r_skip_prev;
    assign w_tick      = r_running && (r_presc == c_PRESC_MAX);
    assign w_cnt_inc   = r_cnt + 4'd1;
    // A skip edge ends the phase on its own and swallows any coincident tick
    assign w_phase_end = (r_state != ST_IDLE) &&
                         (w_skip_edge || (w_tick && (r_min == '0) && (r_sec == '0)));

    always_comb begin
        w_state_nxt   = r_state;
        w_running_nxt = r_running;
        w_min_nxt     = r_min;
        w_sec_nxt     = r_sec;
        w_cnt_nxt     = r_cnt;
        w_presc_nxt   = r_presc;
        w_done_nxt    = 1'b0;
        w_sel_nxt     = r_work_sel;

        if (r_state == ST_IDLE) begin
            {w_min_nxt, w_sec_nxt} = f_work_time(work_sel);
            w_presc_nxt            = '0;
            if (w_sp_edge) begin
                w_state_nxt   = ST_WORK;
                w_running_nxt = 1'b1;
                w_sel_nxt     = work_sel;
            end
        end else if (w_phase_end) begin
            w_done_nxt  = 1'b1;
            w_presc_nxt = '0;
            case (r_state)
                ST_WORK: begin
                    if (w_skip_edge) begin
                        w_state_nxt = ST_SHORT;
                    end else begin
                        w_cnt_nxt   = w_cnt_inc;
                        w_state_nxt = (w_cnt_inc < c_SPL) ? ST_SHORT : ST_LONG;
                    end
                end
                ST_SHORT: w_state_nxt = ST_WORK;
                default: begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = 4'd0;
                end
            endcase

            case (w_state_nxt)
                ST_WORK:  {w_min_nxt, w_sec_nxt} = f_work_time(r_work_sel);
                ST_SHORT: {w_min_nxt, w_sec_nxt} = {c_SHORT_MIN, 6'd0};
                ST_LONG:  {w_min_nxt, w_sec_nxt} = {c_LONG_MIN, 6'd0};
                default:  {w_min_nxt, w_sec_nxt} = f_work_time(work_sel);
            endcase

            w_running_nxt = (w_state_nxt != ST_IDLE) && c_AUTO_ADVANCE;

            // A start edge on the ending cycle acts on the phase being entered
            if (w_sp_edge) begin
                if (w_state_nxt == ST_IDLE) begin
                    w_state_nxt            = ST_WORK;
                    w_running_nxt          = 1'b1;
                    w_sel_nxt              = work_sel;
                    {w_min_nxt, w_sec_nxt} = f_work_time(work_sel);
                end else begin
                    w_running_nxt = ~w_running_nxt;
                end
            end
        end else begin
            if (w_tick) begin
                w_presc_nxt = '0;
                if (r_sec != 6'd0) begin
                    w_sec_nxt = r_sec - 6'd1;
                end else if (r_min != '0) begin
                    w_sec_nxt = 6'd59;
                    w_min_nxt = r_min - MIN_W'(1);
                end
            end else if (r_running) begin
                w_presc_nxt = r_presc + 1'b1;
            end
            if (w_sp_edge) begin
                w_running_nxt = ~r_running;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= ST_IDLE;
            r_running   <= 1'b0;
            r_min       <= '0;
            r_sec       <= 6'd0;
            r_cnt       <= 4'd0;
            r_presc     <= '0;
            r_done      <= 1'b0;
            r_work_sel  <= 2'b00;
            r_sp_prev   <= 1'b0;
            r_skip_prev <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_running   <= w_running_nxt;
            r_min       <= w_min_nxt;
            r_sec       <= w_sec_nxt;
            r_cnt       <= w_cnt_nxt;
            r_presc     <= w_presc_nxt;
            r_done      <= w_done_nxt;
            r_work_sel  <= w_sel_nxt;
            r_sp_prev   <= start_pause;
            r_skip_prev <= skip;
        end
    end

    assign minutes     = r_min;
    assign seconds     = r_sec;
    assign phase       = r_state;
    assign running     = r_running;
    assign session_cnt = r_cnt;
    assign phase_done  = r_done;

endmodule
`default_nettype wire

// File: tb/tb_pomodoro_sequencer.sv
`default_nettype none
// Bench for pomodoro_sequencer: directed + random stimulus, scored against a
// seconds-remaining reference model through per-cycle and phase-end queues.
module tb_pomodoro_sequencer;

    localparam int CLK_HZ    = 10;
    localparam int MIN_W     = 7;
    localparam int SPL       = 2;
    localparam int SHORT_MIN = 1;
    localparam int LONG_MIN  = 2;
`ifdef POMO_AUTO_ADVANCE_EN
    localparam int AUTO = 1;
`else
    localparam int AUTO = 0;
`endif

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             start_pause = 1'b0;
    logic             skip = 1'b0;
    logic [1:0]       work_sel = 2'b00;
    logic [MIN_W-1:0] minutes;
    logic [5:0]       seconds;
    logic [1:0]       phase;
    logic             running;
    logic [3:0]       session_cnt;
    logic             phase_done;

    pomodoro_sequencer #(
        .CLK_HZ(CLK_HZ), .MIN_W(MIN_W), .SESSIONS_PER_LONG(SPL),
        .SHORT_BREAK_MIN(SHORT_MIN), .LONG_BREAK_MIN(LONG_MIN)
    ) dut (
        .clk(clk), .reset(reset), .start_pause(start_pause), .skip(skip),
        .work_sel(work_sel), .minutes(minutes), .seconds(seconds), .phase(phase),
        .running(running), .session_cnt(session_cnt), .phase_done(phase_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int phase;
        int running;
        int rem;
        int cnt;
        int done;
    } snap_t;

    snap_t q_exp[$];
    snap_t q_evt[$];
    int    total = 0;
    int    bad   = 0;

    // Reference model: phase id, total seconds left, running cycles into the current second
    int m_phase = 0, m_running = 0, m_rem = 0, m_cyc = 0, m_cnt = 0, m_sel = 0, m_done = 0;
    int m_prev_sp = 0, m_prev_sk = 0;

    function automatic int work_secs(input int sel);
        case (sel)
            0:       return 10;
            1:       return 20 * 60;
            2:       return 25 * 60;
            default: return 30 * 60;
        endcase
    endfunction

    task automatic m_step(input int rn, input int sp, input int sk, input int ws);
        int sp_e, sk_e, tick;
        m_done = 0;
        if (rn == 0) begin
            m_phase = 0; m_running = 0; m_rem = 0; m_cyc = 0; m_cnt = 0;
            m_sel = 0; m_prev_sp = 0; m_prev_sk = 0;
        end else begin
            sp_e = (sp != 0 && m_prev_sp == 0) ? 1 : 0;
            sk_e = (sk != 0 && m_prev_sk == 0) ? 1 : 0;
            m_prev_sp = sp;
            m_prev_sk = sk;
            if (m_phase == 0) begin
                m_rem = work_secs(ws);
                m_cyc = 0;
                if (sp_e != 0) begin
                    m_phase = 1; m_running = 1; m_sel = ws;
                end
            end else begin
                tick = (m_running != 0 && m_cyc == CLK_HZ - 1) ? 1 : 0;
                if (sk_e != 0 || (tick != 0 && m_rem == 0)) begin
                    m_done = 1;
                    m_cyc  = 0;
                    if (m_phase == 1) begin
                        if (sk_e == 0) m_cnt = m_cnt + 1;
                        m_phase = (sk_e == 0 && m_cnt >= SPL) ? 3 : 2;
                    end else if (m_phase == 2) begin
                        m_phase = 1;
                    end else begin
                        m_phase = 0; m_cnt = 0;
                    end
                    m_running = (m_phase != 0) ? AUTO : 0;
                    if (sp_e != 0 && m_phase == 0) begin
                        m_phase = 1; m_running = 1; m_sel = ws;
                    end else if (sp_e != 0) begin
                        m_running = 1 - m_running;
                    end
                    case (m_phase)
                        0:       m_rem = work_secs(ws);
                        1:       m_rem = work_secs(m_sel);
                        2:       m_rem = SHORT_MIN * 60;
                        default: m_rem = LONG_MIN * 60;
                    endcase
                end else begin
                    if (m_running != 0) begin
                        m_cyc = (m_cyc + 1) % CLK_HZ;
                        if (tick != 0) m_rem = m_rem - 1;
                    end
                    if (sp_e != 0) m_running = 1 - m_running;
                end
            end
        end
        q_exp.push_back('{m_phase, m_running, m_rem, m_cnt, m_done});
        if (m_done != 0) q_evt.push_back('{m_phase, m_running, m_rem, m_cnt, m_done});
    endtask

    task automatic step(input int rn, input int sp, input int sk, input int ws);
        @(negedge clk);
        reset       = (rn != 0);
        start_pause = (sp != 0);
        skip        = (sk != 0);
        work_sel    = 2'(ws);
        m_step(rn, sp, sk, ws);
    endtask

    task automatic settle();
        @(posedge clk);
        #2;
    endtask

    task automatic dcheck(input string name, input int got, input int want);
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, want, $time);
        end
    endtask

    task automatic bound_fail(input string name);
        total++;
        bad++;
        $display("FAIL %s: model condition not reached within cycle budget", name);
    endtask

    task automatic ensure_running(input int ws);
        if (m_running == 0) step(1, 1, 0, ws);
    endtask

    task automatic run_until_phase(input int ph, input int limit, input int ws);
        int n;
        n = 0;
        while (m_phase != ph && n < limit) begin
            step(1, 0, 0, ws);
            n++;
        end
        if (m_phase != ph) bound_fail("reach_phase");
    endtask

    task automatic run_until_rem(input int r, input int limit, input int ws);
        int n;
        n = 0;
        while (m_rem != r && n < limit) begin
            step(1, 0, 0, ws);
            n++;
        end
        if (m_rem != r) bound_fail("reach_remaining");
    endtask

    // Monitor: one expected snapshot per cycle, plus a phase-end event queue
    initial begin
        snap_t            e;
        snap_t            ev;
        logic [MIN_W-1:0] x_min;
        logic [5:0]       x_sec;
        forever begin
            @(posedge clk);
            #1;
            if (q_exp.size() > 0) begin
                e     = q_exp.pop_front();
                x_min = MIN_W'(e.rem / 60);
                x_sec = 6'(e.rem % 60);
                total++;
                if (phase !== e.phase[1:0] || running !== e.running[0] ||
                    minutes !== x_min || seconds !== x_sec ||
                    session_cnt !== e.cnt[3:0] || phase_done !== e.done[0]) begin
                    bad++;
                    $display("FAIL state t=%0t: got ph=%0d run=%0d %0d:%0d cnt=%0d done=%0d expected ph=%0d run=%0d %0d:%0d cnt=%0d done=%0d",
                             $time, phase, running, minutes, seconds, session_cnt, phase_done,
                             e.phase, e.running, x_min, x_sec, e.cnt, e.done);
                end
                if (phase_done === 1'b1) begin
                    total++;
                    if (q_evt.size() == 0) begin
                        bad++;
                        $display("FAIL phase_end t=%0t: got unexpected pulse, expected none", $time);
                    end else begin
                        ev = q_evt.pop_front();
                        if (phase !== ev.phase[1:0] || session_cnt !== ev.cnt[3:0] ||
                            minutes !== MIN_W'(ev.rem / 60) || seconds !== 6'(ev.rem % 60)) begin
                            bad++;
                            $display("FAIL phase_end t=%0t: got ph=%0d cnt=%0d %0d:%0d expected ph=%0d cnt=%0d rem=%0d s",
                                     $time, phase, session_cnt, minutes, seconds, ev.phase, ev.cnt, ev.rem);
                        end
                    end
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, ws, rn, sp, sk;

        // Reset state
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        settle();
        dcheck("reset_phase", phase, 0);
        dcheck("reset_running", running, 0);
        dcheck("reset_minutes", minutes, 0);
        dcheck("reset_seconds", seconds, 0);
        dcheck("reset_cnt", session_cnt, 0);
        dcheck("reset_done", phase_done, 0);

        // Idle load, then 10 s work with a mid-second pause
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        settle();
        dcheck("idle_load_min", minutes, 0);
        dcheck("idle_load_sec", seconds, 10);
        step(1, 1, 0, 0);
        run_until_rem(7, 100, 0);
        repeat (4) step(1, 0, 0, 0);
        step(1, 1, 0, 0);
        repeat (50) step(1, 0, 0, 0);
        settle();
        dcheck("paused_sec", seconds, 7);
        dcheck("paused_running", running, 0);
        step(1, 1, 0, 0);
        run_until_phase(2, 300, 0);
        settle();
        dcheck("brk_phase", phase, 2);
        dcheck("brk_min", minutes, 1);
        dcheck("brk_sec", seconds, 0);
        dcheck("brk_cnt", session_cnt, 1);
        dcheck("brk_running", running, AUTO);

        // Skip coinciding with a tick at 0:04 of WORK
        ensure_running(0);
        step(1, 0, 1, 0);
        ensure_running(0);
        n = 0;
        while (!(m_phase == 1 && m_rem == 4 && m_cyc == CLK_HZ - 1 && m_running != 0) && n < 300) begin
            step(1, 0, 0, 0);
            n++;
        end
        if (n >= 300) bound_fail("reach_skip_tick");
        step(1, 0, 1, 0);
        settle();
        dcheck("skip_phase", phase, 2);
        dcheck("skip_cnt", session_cnt, 1);
        dcheck("skip_min", minutes, 1);
        dcheck("skip_sec", seconds, 0);

        // work_sel ignored outside IDLE; long break; return to IDLE reloads
        step(1, 0, 0, 3);
        step(1, 0, 1, 3);
        settle();
        dcheck("latched_work_min", minutes, 0);
        dcheck("latched_work_sec", seconds, 10);
        ensure_running(3);
        run_until_phase(3, 400, 3);
        settle();
        dcheck("long_phase", phase, 3);
        dcheck("long_cnt", session_cnt, 2);
        dcheck("long_min", minutes, 2);
        step(1, 0, 1, 3);
        step(1, 0, 0, 3);
        settle();
        dcheck("idle_phase", phase, 0);
        dcheck("idle_cnt", session_cnt, 0);
        dcheck("idle_running", running, 0);
        dcheck("idle_min30", minutes, 30);
        dcheck("idle_sec30", seconds, 0);

        // Reset mid short break at 0:33
        step(1, 0, 0, 0);
        step(1, 1, 0, 0);
        step(1, 0, 1, 0);
        ensure_running(0);
        run_until_rem(33, 400, 0);
        step(0, 0, 0, 0);
        #1;
        dcheck("midrst_phase", phase, 0);
        dcheck("midrst_sec", seconds, 0);
        dcheck("midrst_running", running, 0);
        dcheck("midrst_done", phase_done, 0);
        step(0, 0, 0, 0);
        step(1, 0, 0, 0);
        settle();
        dcheck("post_rst_phase", phase, 0);
        dcheck("post_rst_sec", seconds, 10);

        // Randomized traffic
        ws = 0;
        for (int i = 0; i < 6000; i++) begin
            rn = ($urandom_range(0, 999) < 2) ? 0 : 1;
            if ($urandom_range(0, 99) < 2) ws = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 3)) : 0;
            sp = ($urandom_range(0, 99) < 4) ? 1 : 0;
            sk = ($urandom_range(0, 99) < 1) ? 1 : 0;
            step(rn, sp, sk, ws);
        end

        step(1, 0, 0, 0);
        @(posedge clk);
        #3;
        dcheck("exp_queue_drained", q_exp.size(), 0);
        dcheck("evt_queue_drained", q_evt.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pomodoro_sequencer.md
POMODORO_SEQUENCER -- requirements
Module: pomodoro_sequencer

Interface
REQ-001 SHALL have parameter CLK_HZ, default 100000000, meaning input clock cycles per one-second tick.
REQ-002 SHALL have parameter MIN_W, default 7, meaning width of the minutes counter.
REQ-003 SHALL have parameter SESSIONS_PER_LONG, default 4, range 1..15, meaning completed work phases before a long break.
REQ-004 SHALL have parameter SHORT_BREAK_MIN, default 5, meaning short break length in minutes.
REQ-005 SHALL have parameter LONG_BREAK_MIN, default 15, meaning long break length in minutes.
REQ-006 SHALL have port clk  input  1  system clock, rising edge.
REQ-007 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-008 SHALL have port start_pause  input  1  synchronous level; a rising edge toggles run/pause.
REQ-009 SHALL have port skip  input  1  synchronous level; a rising edge aborts the current phase.
REQ-010 SHALL have port work_sel  input  2  work length preset: 00=10 s, 01=20 min, 10=25 min, 11=30 min.
REQ-011 SHALL have port minutes  output  MIN_W  remaining minutes.
REQ-012 SHALL have port seconds  output  6  remaining seconds, 0..59.
REQ-013 SHALL have port phase  output  2  00=IDLE, 01=WORK, 10=SHORT_BREAK, 11=LONG_BREAK.
REQ-014 SHALL have port running  output  1  countdown active.
REQ-015 SHALL have port session_cnt  output  4  work phases completed since the last long break.
REQ-016 SHALL have port phase_done  output  1  one-cycle pulse when a phase ends.

Function
REQ-017 SHALL edge-detect start_pause and skip with a registered previous value; a held level SHALL NOT act twice.
REQ-018 SHALL run a prescaler 0..CLK_HZ-1 only while running=1; the tick SHALL fire on the cycle the prescaler equals CLK_HZ-1, then the prescaler SHALL wrap to 0, giving exactly CLK_HZ cycles per second.
REQ-019 SHALL hold the prescaler while paused and clear it whenever a new phase time is loaded.
REQ-020 In IDLE, SHALL load {minutes, seconds} from work_sel one cycle after any change; work_sel SHALL be ignored outside IDLE.
REQ-021 A start_pause edge in IDLE SHALL enter WORK with running=1; in any other phase it SHALL toggle running.
REQ-022 On a tick with seconds>0, SHALL decrement seconds; with seconds=0 and minutes>0, SHALL set seconds=59 and decrement minutes.
REQ-023 On a tick at 0:00, SHALL assert phase_done for one cycle and transition: WORK->SHORT_BREAK (session_cnt+1 < SESSIONS_PER_LONG), WORK->LONG_BREAK otherwise; SHORT_BREAK->WORK; LONG_BREAK->IDLE with session_cnt cleared to 0.
REQ-024 On completed WORK, session_cnt SHALL increment; in LONG_BREAK it SHALL read SESSIONS_PER_LONG.
REQ-025 On phase entry, SHALL load SHORT_BREAK_MIN:00, LONG_BREAK_MIN:00, or the work_sel value latched at the IDLE start.
REQ-026 A skip edge outside IDLE SHALL end the phase as in REQ-023, except a skipped WORK SHALL NOT increment session_cnt and SHALL go to SHORT_BREAK; skip in IDLE SHALL be ignored.
REQ-027 If a skip edge and a tick coincide, skip SHALL win and the tick SHALL be discarded.
REQ-028 If a start_pause edge and a tick coincide, the tick SHALL be applied and running SHALL toggle in the same cycle.
REQ-029 A start_pause edge coinciding with phase end SHALL be applied to the new phase.
REQ-030 minutes arithmetic SHALL be MIN_W bits and SHALL NOT underflow below 0:00.

Reset
REQ-031 reset=0 SHALL asynchronously force phase=IDLE, running=0, session_cnt=0, phase_done=0, prescaler=0, minutes=0, seconds=0, and edge registers=0; a work_sel load SHALL follow on the first cycle after release.
REQ-032 Reset asserted mid-phase SHALL discard all progress, with no phase_done pulse.

Configuration
REQ-033 With macro POMO_AUTO_ADVANCE_EN defined, running SHALL remain 1 across WORK<->break transitions, and only LONG_BREAK->IDLE SHALL clear it.
REQ-034 Without POMO_AUTO_ADVANCE_EN, every phase end SHALL clear running and load the next phase, which then waits for a start_pause edge.

Verification (CLK_HZ=10, SESSIONS_PER_LONG=2, SHORT_BREAK_MIN=1, LONG_BREAK_MIN=2)
REQ-035 work_sel=00, start_pause edge -> 0:10 counts down one second per 10 clk; at 0:00, phase_done pulses once, phase=10, display 1:00.
REQ-036 Pause edge at 0:07, hold 50 clk, resume -> display stays 0:07 while paused; the next decrement occurs exactly 10 running clk after the pause point, counting the prescaler remainder.
REQ-037 Two completed WORK phases with auto-advance on -> session_cnt=2, phase=11, display 2:00; at the end -> phase=00, session_cnt=0, running=0.
REQ-038 Skip edge during WORK at 0:04 coinciding with a tick -> phase=10, session_cnt unchanged, display 1:00, no decrement applied.
REQ-039 work_sel changed 00->11 during WORK -> display unaffected; after return to IDLE -> 30:00.
REQ-040 reset pulsed low mid-SHORT_BREAK at 0:33 -> all outputs zero immediately; after release, phase=00 and display reflects work_sel.
